imem_loader: RTL
================

Name: imem_loader

Overview:
- Writer side of the core's instruction-memory interface: fills the 32-word IMEM that the pipeline fetches from.
- Accepts a framed byte stream over a valid/ready link and packs it into 32-bit words.
- Writes the words to sequential IMEM addresses from 0, then releases the core from reset.
- Holds the core in reset during loading and after any framing or checksum error.

Parameters:
- ADDR_W, 5, IMEM address width.
- DEPTH, 32, IMEM word count; the maximum legal N.
- MAGIC, 8'hA5, frame start byte.
- TIMEOUT_CYC, 1024, idle cycles allowed between accepted bytes inside a frame.

Ports:
- clk  in  1  clock
- RN  in  1  asynchronous active-low reset
- rx_valid  in  1  byte available
- rx_data  in  8  byte value
- rx_ready  out  1  loader accepts byte this cycle
- imem_we  out  1  IMEM write strobe, one cycle per word
- imem_addr  out  ADDR_W  word address
- imem_wdata  out  32  instruction word
- core_rst  out  1  active-high reset to core; 1 = hold
- load_done  out  1  level; frame loaded and checksum good
- load_err  out  1  level; last frame failed
- words_loaded  out  ADDR_W+1  words written in current frame

Behaviour:
- Reset (RN=0, async): state IDLE; core_rst=1, rx_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, load_done=0, load_err=0, words_loaded=0, checksum=0, byte_idx=0, timer=0.
- Byte accept: a byte is accepted on a clk edge where rx_valid && rx_ready.
- rx_ready is 1 in every state except WRITE and reset.
- Frame format: MAGIC, N (1..DEPTH), 4N data bytes little-endian per word, then 1 checksum byte (XOR of all data bytes).
- IDLE / DONE / ERR:
  - A non-MAGIC byte is discarded.
  - MAGIC goes to LEN, sets core_rst=1, clears load_done, load_err, words_loaded and checksum.
- LEN:
  - N=0 or N>DEPTH goes to ERR.
  - Otherwise latch N and go to DATA with byte_idx=0.
- DATA:
  - Each byte is shifted into word bits [8*byte_idx+7:8*byte_idx] and XORed into checksum; byte_idx increments mod 4.
  - When the 4th byte is accepted, go to WRITE.
- WRITE (exactly one cycle):
  - imem_we=1, imem_addr=words_loaded[ADDR_W-1:0], imem_wdata=packed word.
  - words_loaded increments at the end of the cycle.
  - Next state is DATA if the incremented count is below N, else CHECK.
  - The word is written in the cycle after its 4th byte is accepted.
- CHECK:
  - A matching checksum byte goes to DONE: load_done=1 and core_rst=0 from the next cycle.
  - A mismatch goes to ERR.
- ERR: load_err=1, core_rst stays 1. IMEM contents already written are not rolled back.
- Timeout:
  - In LEN, DATA and CHECK, timer counts cycles with no accepted byte and clears on each accept.
  - Reaching TIMEOUT_CYC goes to ERR.
  - The timer does not run in WRITE, IDLE, DONE or ERR.
- MAGIC inside a frame (LEN/DATA/CHECK) is treated as ordinary data. Resync happens only from IDLE, DONE or ERR.
- A reload from DONE reasserts core_rst in the same cycle the state changes to LEN.
- Reset mid-frame: all state is aborted asynchronously and core_rst=1 immediately; IMEM is untouched.
- At most one IMEM write per frame word; imem_addr never exceeds N-1.

Decomposition:
- Shared package holds:
  - state enum: IDLE, LEN, DATA, WRITE, CHECK, DONE, ERR;
  - MAGIC;
  - DEPTH/ADDR_W defaults, matching the core's IMEM size.
- One natural sub-module: byte_packer (shift-in of 4 bytes, byte_idx, running XOR checksum).
- FSM and timer stay in the top.

Test Plan:
- Good 2-word load:
  - Stimulus: A5 02 00 83 20 02 80 93 20 02 90, rx_valid held high.
  - Expected: imem_we pulses at addr 0 with 0x02208300, then at addr 1 with 0x02209380.
  - Expected: load_done=1, core_rst=0, words_loaded=2, rx_ready=0 only in the two WRITE cycles.
- Checksum error: same frame with final byte 91 -> both words still written; load_err=1, core_rst=1, load_done=0.
- Bad length: A5 00 -> ERR. A5 21 -> ERR. No imem_we in either case.
- Noise then resync:
  - Stimulus: 3C 11 while IDLE are ignored, then a valid frame A5 01 00 00 00 00 00.
  - Expected: write 0x00000000 at addr 0, then DONE.
- Timeout: A5 01 12 then rx_valid=0 for TIMEOUT_CYC cycles -> load_err=1, no write. A following valid frame loads correctly.
- Reset during DATA: RN low after 2 data bytes -> core_rst=1 immediately, outputs at reset values, no imem_we. A later full frame succeeds.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// imem_loader shared types: FSM state encoding, frame magic byte,
// default IMEM geometry and a byte-lane insert helper.
package imem_loader_pkg;

  localparam int unsigned IMEM_ADDR_W = 5;
  localparam int unsigned IMEM_DEPTH  = 32;
  localparam logic [7:0]  FRAME_MAGIC = 8'hA5;
  localparam int unsigned RX_TIMEOUT  = 1024;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_WRITE,
    S_CHECK,
    S_DONE,
    S_ERR
  } state_t;

  function automatic logic [31:0] put_byte(
    input logic [31:0] word,
    input logic [1:0]  idx,
    input logic [7:0]  b
  );
    logic [31:0] w;
    w = word;
    w[8*idx +: 8] = b;
    return w;
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream link (rx_valid/rx_data/rx_ready) plus IMEM write bus.
// master: loader side (drives rx_ready, imem_*); slave: source/IMEM side.
interface imem_loader_if
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W
) ();

  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    input  rx_valid,
    input  rx_data,
    output rx_ready,
    output imem_we,
    output imem_addr,
    output imem_wdata
  );

  modport slave (
    output rx_valid,
    output rx_data,
    input  rx_ready,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata
  );

endinterface

// File: rtl/imem_loader_byte_packer.sv
// Packs 4 little-endian bytes into a word and keeps the running XOR.
// i_clr restarts a frame, i_shift accepts i_data; o_last marks byte 3.
module imem_loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clr,
  input  logic        i_shift,
  input  logic [7:0]  i_data,
  output logic [31:0] o_word_nxt,
  output logic        o_last,
  output logic [7:0]  o_csum
);

  logic [31:0] r_word;
  logic [1:0]  r_idx;
  logic [7:0]  r_csum;

  // word as it will look once i_data lands in its lane
  assign o_word_nxt = put_byte(r_word, r_idx, i_data);
  assign o_last     = (r_idx == 2'd3);
  assign o_csum     = r_csum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word <= '0;
      r_idx  <= '0;
      r_csum <= '0;
    end else if (i_clr) begin
      r_word <= '0;
      r_idx  <= '0;
      r_csum <= '0;
    end else if (i_shift) begin
      r_word <= o_word_nxt;
      r_idx  <= r_idx + 2'd1;
      r_csum <= r_csum ^ i_data;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Frame loader: MAGIC, N, 4N data bytes, XOR checksum -> IMEM words 0..N-1.
// Ports: clk, RN, bus (link + IMEM write), core_rst, load_done, load_err, words_loaded.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int         ADDR_W      = IMEM_ADDR_W,
  parameter int         DEPTH       = IMEM_DEPTH,
  parameter logic [7:0] MAGIC       = FRAME_MAGIC,
  parameter int         TIMEOUT_CYC = RX_TIMEOUT
) (
  input  logic              clk,
  input  logic              RN,
  imem_loader_if.master     bus,
  output logic              core_rst,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int TW = $clog2(TIMEOUT_CYC) + 1;

  state_t            r_state;
  logic              r_rdy;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_core_rst;
  logic              r_done;
  logic              r_err;
  logic [ADDR_W:0]   r_words;
  logic [ADDR_W:0]   r_n;
  logic [TW-1:0]     r_timer;

  logic              w_acc;
  logic              w_rest;
  logic              w_clr;
  logic              w_shift;
  logic              w_len_bad;
  logic              w_tmo;
  logic [ADDR_W:0]   w_words_inc;
  logic [31:0]       w_word_nxt;
  logic              w_last;
  logic [7:0]        w_csum;

  assign w_acc       = bus.rx_valid & r_rdy;
  assign w_rest      = r_state inside {S_IDLE, S_DONE, S_ERR};
  assign w_clr       = w_acc & w_rest & (bus.rx_data == MAGIC);
  assign w_shift     = w_acc & (r_state == S_DATA);
  assign w_len_bad   = (bus.rx_data == 8'd0) ||
                       (bus.rx_data > 8'(DEPTH));
  assign w_tmo       = (r_timer == TW'(TIMEOUT_CYC - 1));
  assign w_words_inc = r_words + 1'b1;

  imem_loader_byte_packer u_pack (
    .clk        (clk),
    .rst_n      (RN),
    .i_clr      (w_clr),
    .i_shift    (w_shift),
    .i_data     (bus.rx_data),
    .o_word_nxt (w_word_nxt),
    .o_last     (w_last),
    .o_csum     (w_csum)
  );

  always_ff @(posedge clk or negedge RN) begin
    if (!RN) begin
      r_state    <= S_IDLE;
      r_rdy      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_core_rst <= 1'b1;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_words    <= '0;
      r_n        <= '0;
      r_timer    <= '0;
    end else begin
      // ready drops only for the single WRITE cycle
      r_rdy <= 1'b1;
      r_we  <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (w_clr) begin
            r_state    <= S_LEN;
            r_core_rst <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_words    <= '0;
            r_timer    <= '0;
          end
        end
        S_LEN: begin
          if (w_acc) begin
            r_timer <= '0;
            if (w_len_bad) begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
            end else begin
              r_n     <= bus.rx_data[ADDR_W:0];
              r_state <= S_DATA;
            end
          end else if (w_tmo) begin
            r_state <= S_ERR;
            r_err   <= 1'b1;
            r_timer <= '0;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_DATA: begin
          if (w_acc) begin
            r_timer <= '0;
            if (w_last) begin
              r_state <= S_WRITE;
              r_rdy   <= 1'b0;
              r_we    <= 1'b1;
              r_addr  <= r_words[ADDR_W-1:0];
              r_wdata <= w_word_nxt;
            end
          end else if (w_tmo) begin
            r_state <= S_ERR;
            r_err   <= 1'b1;
            r_timer <= '0;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_WRITE: begin
          r_words <= w_words_inc;
          r_state <= (w_words_inc < r_n) ? S_DATA : S_CHECK;
        end
        S_CHECK: begin
          if (w_acc) begin
            r_timer <= '0;
            if (bus.rx_data == w_csum) begin
              r_state    <= S_DONE;
              r_done     <= 1'b1;
              r_core_rst <= 1'b0;
            end else begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
            end
          end else if (w_tmo) begin
            r_state <= S_ERR;
            r_err   <= 1'b1;
            r_timer <= '0;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.rx_ready   = r_rdy;
  assign bus.imem_we    = r_we;
  assign bus.imem_addr  = r_addr;
  assign bus.imem_wdata = r_wdata;
  assign core_rst       = r_core_rst;
  assign load_done      = r_done;
  assign load_err       = r_err;
  assign words_loaded   = r_words;

endmodule
